// File: rtl/btn_updown_counter_if.sv
// btn_updown_counter_if: button, mode and clear inputs plus count/tick/limit outputs of the up/down counter
interface btn_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             btn_up;
    logic             btn_dn;
    logic             mode_sat;
    logic             clear;
    logic [WIDTH-1:0] q;
    logic             tick_up;
    logic             tick_dn;
    logic             at_max;
    logic             at_min;

    modport master (
        output btn_up, btn_dn, mode_sat, clear,
        input  q, tick_up, tick_dn, at_max, at_min
    );

    modport slave (
        input  btn_up, btn_dn, mode_sat, clear,
        output q, tick_up, tick_dn, at_max, at_min
    );
endinterface

// File: rtl/btn_updown_counter.sv
// btn_updown_counter: two debounced buttons stepping a modulo-(MAX_VAL+1) up/down counter with wrap/saturate
module btn_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_VAL   = 255,
    parameter int DB_CYCLES = 500000,
    parameter int DB_CW     = 20
) (
    input logic                clk,
    input logic                reset,
    btn_updown_counter_if.slave bus
);
    typedef enum logic [1:0] {REL, WAIT_P, PRS, WAIT_R} db_state_t;

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
    localparam logic [DB_CW-1:0] LAST = DB_CW'(DB_CYCLES - 1);

    if (MAX_VAL < 1 || longint'(MAX_VAL) >= (64'd1 << WIDTH)) begin : g_bad_max
        $error("MAX_VAL out of range for WIDTH");
    end
    if (DB_CYCLES < 2 || (64'd1 << DB_CW) <= longint'(DB_CYCLES)) begin : g_bad_db
        $error("DB_CYCLES below 2 or not representable in DB_CW bits");
    end

    logic [1:0]       raw;
    logic [1:0]       tick;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;

    assign raw = {bus.btn_dn, bus.btn_up};

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic             s1;
        logic             s;
        logic             tk;
        logic             tk_nxt;
        db_state_t        st;
        db_state_t        st_nxt;
        logic [DB_CW-1:0] cnt;
        logic [DB_CW-1:0] cnt_nxt;

        // synchronise the raw button and register the debounce state, count and tick
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                s1  <= 1'b0;
                s   <= 1'b0;
                st  <= REL;
                cnt <= '0;
                tk  <= 1'b0;
            end else begin
                s1  <= raw[i];
                s   <= s1;
                st  <= st_nxt;
                cnt <= cnt_nxt;
                tk  <= tk_nxt;
            end
        end

        // accept a level only after DB_CYCLES stable samples; tick once on press acceptance
        always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            tk_nxt  = 1'b0;
            case (st)
                REL: begin
                    if (s) begin
                        st_nxt  = WAIT_P;
                        cnt_nxt = '0;
                    end
                end
                WAIT_P: begin
                    if (!s) st_nxt = REL;
                    else if (cnt == LAST) begin
                        st_nxt = PRS;
                        tk_nxt = 1'b1;
                    end else cnt_nxt = cnt + DB_CW'(1);
                end
                PRS: begin
                    if (!s) begin
                        st_nxt  = WAIT_R;
                        cnt_nxt = '0;
                    end
                end
                WAIT_R: begin
                    if (s) st_nxt = PRS;
                    else if (cnt == LAST) st_nxt = REL;
                    else cnt_nxt = cnt + DB_CW'(1);
                end
                default: st_nxt = REL;
            endcase
        end

        assign tick[i] = tk;
    end

    // clear beats everything; coincident ticks cancel; limits wrap or hold by mode_sat
    always_comb begin
        q_nxt = q;
        q_nxt = bus.clear                ? '0 :
                (tick[0] && !tick[1])    ? ((q == MAXV) ? (bus.mode_sat ? q : '0)   : q + WIDTH'(1)) :
                (tick[1] && !tick[0])    ? ((q == '0)   ? (bus.mode_sat ? q : MAXV) : q - WIDTH'(1)) :
                q;
    end

    // count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q <= '0;
        else        q <= q_nxt;
    end

    assign bus.q       = q;
    assign bus.tick_up = tick[0];
    assign bus.tick_dn = tick[1];
    assign bus.at_max  = (q == MAXV);
    assign bus.at_min  = (q == '0);
endmodule
